// File: rtl/midi_mmio_pkg.sv
// Shared register map for the MIDI MMIO responder: word offsets and bit
// positions in the RX_STATUS and CTRL registers.
package midi_mmio_pkg;

  localparam logic [1:0] OFS_RX_DATA   = 2'd0;
  localparam logic [1:0] OFS_RX_STATUS = 2'd1;
  localparam logic [1:0] OFS_CTRL      = 2'd2;
  localparam logic [1:0] OFS_TSTAMP    = 2'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_POP     = 0;
  localparam int CTRL_CLR_OVF = 1;
  localparam int CTRL_FLUSH   = 2;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with same-cycle push/pop on a full queue and a priority flush.
// Storage is deliberately left out of reset; only pointers and count clear.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && !flush && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/midi_mmio_responder.sv
// MMIO window exposing a MIDI receive FIFO, status, one-shot control and,
// when MIDI_MMIO_TSTAMP_EN is defined, a loadable free-running timestamp.
module midi_mmio_responder
  import midi_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic [7:0]  midi_byte,
  input  logic        midi_valid,
  output logic        hit,
  output logic [31:0] q_mmio
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    ofs;
  logic          ctrl_wr;
  logic          pop_req;
  logic          clr_req;
  logic          flush_req;
  logic          overflow;
  logic          overflow_set;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic [7:0]    count8;
  logic          full;
  logic          empty;
  logic [31:0]   rd_mux;

  assign hit       = (address_dmem[31:2] == BASE_ADDR[31:2]);
  assign ofs       = address_dmem[1:0];
  assign ctrl_wr   = hit && wren && (ofs == OFS_CTRL);
  assign pop_req   = ctrl_wr && data[CTRL_POP];
  assign clr_req   = ctrl_wr && data[CTRL_CLR_OVF];
  assign flush_req = ctrl_wr && data[CTRL_FLUSH];
  assign count8    = 8'(count);

  // A flushed push is discarded silently, so it never counts as overflow.
  assign overflow_set = midi_valid && full && !pop_req && !flush_req;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (midi_valid),
    .din   (midi_byte),
    .pop   (pop_req),
    .flush (flush_req),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock) begin
    if (!reset)            overflow <= 1'b0;
    else if (overflow_set) overflow <= 1'b1;
    else if (clr_req)      overflow <= 1'b0;
  end

`ifdef MIDI_MMIO_TSTAMP_EN
  logic [31:0] tstamp;

  always_ff @(posedge clock) begin
    if (!reset)                                 tstamp <= '0;
    else if (hit && wren && ofs == OFS_TSTAMP)  tstamp <= data;
    else                                        tstamp <= tstamp + 32'd1;
  end
`else
  logic unused_data_bits;
  assign unused_data_bits = ^data[31:3];
`endif

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (ofs)
        OFS_RX_DATA: begin
          if (!empty) rd_mux = {23'b0, 1'b1, head};
        end
        OFS_RX_STATUS: begin
          rd_mux[ST_EMPTY]                      = empty;
          rd_mux[ST_FULL]                       = full;
          rd_mux[ST_OVERFLOW]                   = overflow;
          rd_mux[ST_COUNT_LSB+7:ST_COUNT_LSB]   = count8;
        end
        OFS_TSTAMP: begin
`ifdef MIDI_MMIO_TSTAMP_EN
          rd_mux = tstamp;
`endif
        end
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) q_mmio <= '0;
    else        q_mmio <= rd_mux;
  end

endmodule

// File: tb/tb_midi_mmio_responder.sv
// Directed self-checking bench for midi_mmio_responder (DEPTH=16); the
// timestamp scenario is built only when MIDI_MMIO_TSTAMP_EN is defined.
module tb_midi_mmio_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [7:0]  midi_byte = '0;
  logic        midi_valid = 1'b0;
  logic        hit;
  logic [31:0] q_mmio;

  int passed = 0;
  int total  = 0;
  logic [31:0] v;

  midi_mmio_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .midi_byte    (midi_byte),
    .midi_valid   (midi_valid),
    .hit          (hit),
    .q_mmio       (q_mmio)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [1:0] ofs, output logic [31:0] val);
    address_dmem = BASE + 32'(ofs);
    wren = 1'b0;
    midi_valid = 1'b0;
    tick();
    val = q_mmio;
    address_dmem = '0;
  endtask

  task automatic do_write(input logic [1:0] ofs, input logic [31:0] d);
    address_dmem = BASE + 32'(ofs);
    data = d;
    wren = 1'b1;
    tick();
    wren = 1'b0;
    address_dmem = '0;
  endtask

  task automatic do_push(input logic [7:0] b);
    midi_byte = b;
    midi_valid = 1'b1;
    tick();
    midi_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (q_mmio !== 32'h0) $display("[TB] FAIL reset_q: got %h expected %h", q_mmio, 32'h0);
    else passed++;
    reset = 1'b1;
    address_dmem = BASE + 32'd1;
    #1;
    total++;
    if (hit !== 1'b1) $display("[TB] FAIL hit_in_window: got %b expected %b", hit, 1'b1);
    else passed++;
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0001) $display("[TB] FAIL reset_status: got %h expected %h", v, 32'h1);
    else passed++;
    address_dmem = BASE + 32'd4;
    #1;
    total++;
    if (hit !== 1'b0) $display("[TB] FAIL hit_outside: got %b expected %b", hit, 1'b0);
    else passed++;
    tick();
    total++;
    if (q_mmio !== 32'h0) $display("[TB] FAIL q_outside: got %h expected %h", q_mmio, 32'h0);
    else passed++;
    address_dmem = '0;
  endtask

  task automatic test_push_pop();
    do_push(8'h90);
    do_push(8'h3C);
    do_push(8'h7F);
    do_read(2'd0, v);
    total++;
    if (v !== 32'h0000_0190) $display("[TB] FAIL head_first: got %h expected %h", v, 32'h190);
    else passed++;
    do_write(2'd2, 32'h1);
    do_read(2'd0, v);
    total++;
    if (v !== 32'h0000_013C) $display("[TB] FAIL head_after_pop: got %h expected %h", v, 32'h13C);
    else passed++;
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0200) $display("[TB] FAIL status_count2: got %h expected %h", v, 32'h200);
    else passed++;
    do_read(2'd2, v);
    total++;
    if (v !== 32'h0) $display("[TB] FAIL ctrl_reads_zero: got %h expected %h", v, 32'h0);
    else passed++;
  endtask

  task automatic test_overflow();
    do_write(2'd2, 32'h4);
    for (int i = 0; i <= DEPTH; i++) do_push(8'(i));
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_1006) $display("[TB] FAIL status_overflow: got %h expected %h", v, 32'h1006);
    else passed++;
    do_write(2'd2, 32'h2);
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_1002) $display("[TB] FAIL status_ovf_cleared: got %h expected %h", v, 32'h1002);
    else passed++;
  endtask

  task automatic test_full_pop_push();
    address_dmem = BASE + 32'd2;
    data = 32'h1;
    wren = 1'b1;
    midi_byte = 8'hA5;
    midi_valid = 1'b1;
    tick();
    wren = 1'b0;
    midi_valid = 1'b0;
    address_dmem = '0;
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_1002) $display("[TB] FAIL full_pop_push_status: got %h expected %h", v, 32'h1002);
    else passed++;
    do_read(2'd0, v);
    total++;
    if (v !== 32'h0000_0101) $display("[TB] FAIL full_pop_push_head: got %h expected %h", v, 32'h101);
    else passed++;
    for (int i = 0; i < DEPTH - 1; i++) do_write(2'd2, 32'h1);
    do_read(2'd0, v);
    total++;
    if (v !== 32'h0000_01A5) $display("[TB] FAIL wrap_head: got %h expected %h", v, 32'h1A5);
    else passed++;
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0100) $display("[TB] FAIL wrap_count: got %h expected %h", v, 32'h100);
    else passed++;
  endtask

  task automatic test_clear_vs_set();
    do_write(2'd2, 32'h4);
    for (int i = 0; i < DEPTH; i++) do_push(8'(i + 32));
    address_dmem = BASE + 32'd2;
    data = 32'h2;
    wren = 1'b1;
    midi_byte = 8'h55;
    midi_valid = 1'b1;
    tick();
    wren = 1'b0;
    midi_valid = 1'b0;
    address_dmem = '0;
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_1006) $display("[TB] FAIL clear_vs_set: got %h expected %h", v, 32'h1006);
    else passed++;
  endtask

  task automatic test_flush();
    address_dmem = BASE + 32'd2;
    data = 32'h4;
    wren = 1'b1;
    midi_byte = 8'h11;
    midi_valid = 1'b1;
    tick();
    wren = 1'b0;
    midi_valid = 1'b0;
    address_dmem = '0;
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0005) $display("[TB] FAIL flush_keeps_ovf: got %h expected %h", v, 32'h5);
    else passed++;
    do_write(2'd2, 32'h2);
    do_push(8'h22);
    address_dmem = BASE + 32'd2;
    data = 32'h4;
    wren = 1'b1;
    midi_byte = 8'h33;
    midi_valid = 1'b1;
    tick();
    wren = 1'b0;
    midi_valid = 1'b0;
    address_dmem = '0;
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0001) $display("[TB] FAIL flush_with_push: got %h expected %h", v, 32'h1);
    else passed++;
    do_write(2'd2, 32'h1);
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0001) $display("[TB] FAIL pop_empty_status: got %h expected %h", v, 32'h1);
    else passed++;
    do_read(2'd0, v);
    total++;
    if (v !== 32'h0) $display("[TB] FAIL empty_data: got %h expected %h", v, 32'h0);
    else passed++;
  endtask

  task automatic test_ignored_writes();
    do_push(8'h42);
    do_write(2'd0, 32'hFFFF_FFFF);
    do_write(2'd1, 32'hFFFF_FFFF);
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0100) $display("[TB] FAIL ro_write_status: got %h expected %h", v, 32'h100);
    else passed++;
    do_read(2'd0, v);
    total++;
    if (v !== 32'h0000_0142) $display("[TB] FAIL ro_write_data: got %h expected %h", v, 32'h142);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_write(2'd2, 32'h4);
    for (int i = 0; i < 5; i++) do_push(8'(i + 8'h60));
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0500) $display("[TB] FAIL pre_reset_count: got %h expected %h", v, 32'h500);
    else passed++;
    address_dmem = BASE + 32'd1;
    midi_byte = 8'h77;
    midi_valid = 1'b1;
    reset = 1'b0;
    tick();
    total++;
    if (q_mmio !== 32'h0) $display("[TB] FAIL reset_mid_q: got %h expected %h", q_mmio, 32'h0);
    else passed++;
    reset = 1'b1;
    midi_valid = 1'b0;
    do_read(2'd1, v);
    total++;
    if (v !== 32'h0000_0001) $display("[TB] FAIL reset_mid_status: got %h expected %h", v, 32'h1);
    else passed++;
  endtask

`ifdef MIDI_MMIO_TSTAMP_EN
  task automatic test_tstamp();
    do_write(2'd3, 32'hFFFF_FFFE);
    do_read(2'd3, v);
    total++;
    if (v !== 32'hFFFF_FFFE) $display("[TB] FAIL tstamp_load: got %h expected %h", v, 32'hFFFF_FFFE);
    else passed++;
    do_read(2'd3, v);
    total++;
    if (v !== 32'hFFFF_FFFF) $display("[TB] FAIL tstamp_inc: got %h expected %h", v, 32'hFFFF_FFFF);
    else passed++;
    do_read(2'd3, v);
    total++;
    if (v !== 32'h0) $display("[TB] FAIL tstamp_wrap: got %h expected %h", v, 32'h0);
    else passed++;
  endtask
`else
  task automatic test_tstamp();
    do_write(2'd3, 32'h1234_5678);
    do_read(2'd3, v);
    total++;
    if (v !== 32'h0) $display("[TB] FAIL tstamp_absent: got %h expected %h", v, 32'h0);
    else passed++;
  endtask
`endif

  initial begin
    $display("[TB] starting midi_mmio_responder bench");
    test_reset();
    test_push_pop();
    test_overflow();
    test_full_pop_push();
    test_clear_vs_set();
    test_flush();
    test_ignored_writes();
    test_reset_mid();
    test_tstamp();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
